md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 136 +++++++++++++
 tb/tb_md_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply/divide unit with a fixed-latency busy window.
// Operands and the op are latched at issue. The result is written to HI/LO
// when the down-counter expires, and done pulses for the cycle after that.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    // Result datapath, evaluated from the latched operands only
    logic        sgn, a_neg, b_neg;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // All state, reset asynchronously to an idle block with cleared HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Multiply via sign/zero extension to 64 bits; divide on magnitudes,
    // with the quotient sign from the operand signs and the remainder sign
    // from the dividend.
    always_comb begin
        sgn   = ~op_q[0];
        a_ext = {{32{sgn & a_q[31]}}, a_q};
        b_ext = {{32{sgn & b_q[31]}}, b_q};
        prod  = a_ext * b_ext;
        a_neg = sgn & a_q[31];
        b_neg = sgn & b_q[31];
        a_mag = a_neg ? (32'd0 - a_q) : a_q;
        b_mag = b_neg ? (32'd0 - b_q) : b_q;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (b_q != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next state: issue/mthi/mtlo from IDLE; count down and retire in BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d = BUSY;
                            op_d    = md_op[1:0];
                            a_d     = rs_val;
                            b_d     = rt_val;
                            cnt_d   = md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        end
                        3'd4:    hi_d = rs_val;
                        3'd5:    lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; stall also covers the issue cycle of a multi-cycle op
    always_comb begin
        busy  = (state_q == BUSY);
        stall = md_use_d & ((state_q == BUSY) | (start & (md_op <= 3'd3)));
        done  = done_q;
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and random stimulus against a cycle-count/arithmetic
// reference model of the HI/LO unit.
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        md_use_d = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int errs = 0;
    int checks = 0;

    // reference model state
    int          m_busy;
    bit          m_done;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_ok;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; p_ok = 0; p_hi = 0; p_lo = 0;
    endtask

    // compute the eventual result of an op from its operands
    task automatic model_issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint sa, sb, sp, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        p_ok = 1;
        case (op)
            3'd0: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; end
            3'd1: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; end
            3'd2: if (rt == 0) p_ok = 0;
                  else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
            default: if (rt == 0) p_ok = 0;
                  else begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
        endcase
        m_busy = (op < 3'd2) ? MC : DC;
    endtask

    // one clock: drive inputs, check stall, step model at the edge, check outputs
    task automatic cyc(input bit s, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input bit u);
        bit nd;
        start = s; md_op = op; rs_val = rs; rt_val = rt; md_use_d = u;
        #1;
        chk("stall", {31'd0, stall}, {31'd0, u & ((m_busy > 0) | (s & (op <= 3'd3)))});
        @(posedge clk);
        nd = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (p_ok) begin m_hi = p_hi; m_lo = p_lo; end
                nd = 1;
            end
        end else if (s) begin
            if (op <= 3'd3) model_issue(op, rs, rt);
            else if (op == 3'd4) m_hi = rs;
            else if (op == 3'd5) m_lo = rs;
        end
        m_done = nd;
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_busy > 0});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle(input int n, input bit u);
        for (int i = 0; i < n; i++) cyc(0, 3'($urandom_range(0, 7)), $urandom, $urandom, u);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        start = 1; md_op = 3'd2; md_use_d = 1; #1;
        chk("rst_stall_div", {31'd0, stall}, 32'd1);
        md_op = 3'd4; #1;
        chk("rst_stall_mthi", {31'd0, stall}, 32'd0);
        start = 0; md_use_d = 0;
        @(negedge clk) rst_n = 1'b1;

        // mtlo
        cyc(1, 3'd5, 32'h12345678, 32'd0, 0);
        chk("mtlo_lo", lo, 32'h12345678);

        // multu max x max
        cyc(1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        idle(MC, 0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        chk("multu_done", {31'd0, done}, 32'd1);

        // mult -3 x 4, then div -7/2 issued in the done cycle with stall watched
        cyc(1, 3'd0, 32'hFFFFFFFD, 32'd4, 0);
        idle(MC, 0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF4);
        cyc(1, 3'd2, 32'hFFFFFFF9, 32'd2, 1);
        idle(DC, 1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        cyc(0, 3'd0, 32'd0, 32'd0, 1);   // done cycle was the previous one; stall low here too
        cyc(1, 3'd3, 32'd100, 32'd7, 0);
        idle(DC, 0);

        // divu by zero, mthi ignored while busy
        cyc(1, 3'd4, 32'h11111111, 32'd0, 0);
        cyc(1, 3'd5, 32'h22222222, 32'd0, 0);
        cyc(1, 3'd3, 32'h55555555, 32'd0, 0);
        idle(4, 0);
        cyc(1, 3'd4, 32'hAAAAAAAA, 32'd0, 0);
        idle(5, 0);
        chk("div0_hi", hi, 32'h11111111);
        chk("div0_lo", lo, 32'h22222222);
        chk("div0_done", {31'd0, done}, 32'd1);

        // signed overflow case
        cyc(1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        idle(DC, 0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);

        // reserved ops
        cyc(1, 3'd6, 32'h1, 32'h2, 1);
        cyc(1, 3'd7, 32'h3, 32'h4, 1);

        // async reset two cycles into a mult
        cyc(1, 3'd0, 32'd7, 32'd9, 0);
        idle(2, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1, 3'd0, 32'd3, 32'd5, 0);
        idle(MC, 0);
        chk("post_rst_lo", lo, 32'd15);
        chk("post_rst_done", {31'd0, done}, 32'd1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 7) == 0) rt = 32'd0;
            else if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(0, 20)) - 32'd10;
            cyc($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom, rt,
                1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
